// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM32 bank between the FSX pixel
// fetch path (absolute priority, never stalled) and a single-word CPU port.
// CPU accesses are slotted into cycles with no FSX fetch, optionally only
// while display-enable is low.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter bit          BLANK_ONLY = 1'b0,
  parameter int unsigned MAX_WAIT   = 1023
) (
  input  logic              vga_clk,
  input  logic              resetn,
  input  logic              o_de,
  input  logic              gpu_req,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic              cpu_start,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_starve,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_q
);

  localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              grant;
  logic              blank_ok;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_inc;

  assign blank_ok     = (BLANK_ONLY == 1'b0) | ~o_de;
  assign wait_cnt_inc = wait_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge vga_clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and VRAM port mux (FSX owns the port unless granted)
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    vram_addr = gpu_addr;
    vram_d    = req_data;
    vram_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (!gpu_req && blank_ok) begin
          grant     = 1'b1;
          vram_addr = req_addr;
          vram_we   = req_we;
          state_nxt = req_we ? S_DONE : S_WAIT;
        end
      end
      S_WAIT:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch, wait/starvation tracking, read capture and status flags
  always_ff @(posedge vga_clk or negedge resetn) begin
    if (!resetn) begin
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      wait_cnt   <= '0;
      cpu_starve <= 1'b0;
      cpu_q      <= '0;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
    end else begin
      cpu_busy <= (state_nxt != S_IDLE);
      cpu_done <= (state_nxt == S_DONE);
      if (state == S_IDLE && cpu_start) begin
        req_we     <= cpu_we;
        req_addr   <= cpu_addr;
        req_data   <= cpu_data;
        wait_cnt   <= '0;
        cpu_starve <= 1'b0;
      end else if (state == S_ISSUE && !grant) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == WAIT_MAX) cpu_starve <= 1'b1;
      end
      if (state == S_WAIT) cpu_q <= vram_q;
    end
  end

endmodule
